// File: rtl/abs_diff_approx_pipe.sv
// Two-stage |A-B| pipeline with per-transaction exact/approximate (LSB-truncated) result.
// Optional error monitor enabled by defining ABS_DIFF_ERR_MON_EN.
module abs_diff_approx_pipe #(
   parameter int W     = 4,
   parameter int TRUNC = 1,
   parameter int ET    = 3,
   parameter int CNT_W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_exact,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_diff,
   output logic         out_sign
`ifdef ABS_DIFF_ERR_MON_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   localparam logic [W-1:0] TRUNC_MASK = W'((1 << TRUNC) - 1);

   if (W < 2 || TRUNC < 0 || TRUNC >= W || ET < 0 || CNT_W < 1) begin : g_bad_cfg
      $error("abs_diff_approx_pipe: illegal parameter combination");
   end

   function automatic logic [W-1:0] magnitude(input logic signed [W:0] d);
      magnitude = d[W] ? W'(-d) : d[W-1:0];
   endfunction

   function automatic logic [W-1:0] truncate(input logic [W-1:0] mag, input logic exact);
      truncate = exact ? mag : (mag & ~TRUNC_MASK);
   endfunction

   logic                vld_p0;
   logic [W-1:0]        a_p0;
   logic [W-1:0]        b_p0;
   logic                exact_p0;
   logic signed [W:0]   sub_p0;
   logic [W-1:0]        mag_p0;

   logic                vld_p1;
   logic [W-1:0]        diff_p1;
   logic                sign_p1;

   logic                load_p1;
   logic                accept;

   // S2 refills whenever it is empty or its result leaves this cycle
   assign load_p1  = vld_p0 & (~vld_p1 | out_ready);
   assign in_ready = ~vld_p0 | load_p1;
   assign accept   = in_valid & in_ready;

   assign sub_p0 = signed'({1'b0, a_p0}) - signed'({1'b0, b_p0});
   assign mag_p0 = magnitude(sub_p0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         diff_p1 <= '0;
         sign_p1 <= 1'b0;
      end else begin
         if (accept)
            vld_p0 <= 1'b1;
         else if (load_p1)
            vld_p0 <= 1'b0;

         if (load_p1) begin
            vld_p1  <= 1'b1;
            diff_p1 <= truncate(mag_p0, exact_p0);
            sign_p1 <= sub_p0[W];
         end else if (out_ready) begin
            vld_p1  <= 1'b0;
         end
      end
   end

   // ---- stage S1: operand capture ----
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0     <= in_a;
         b_p0     <= in_b;
         exact_p0 <= in_exact;
      end
   end

   // ---- stage S2: result presentation ----
   assign out_valid = vld_p1;
   assign out_diff  = diff_p1;
   assign out_sign  = sign_p1;

`ifdef ABS_DIFF_ERR_MON_EN
   logic [W-1:0] lost_p0;
   logic         err_p0;
   logic         err_p1;

   // Truncation error is exactly the discarded low bits of the exact magnitude
   assign lost_p0 = mag_p0 & TRUNC_MASK;
   assign err_p0  = ~exact_p0 & (32'(lost_p0) > 32'(ET));

   always_ff @(posedge clk) begin
      if (load_p1)
         err_p1 <= err_p0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if (vld_p1 && out_ready && err_p1 && (err_cnt != {CNT_W{1'b1}}))
         err_cnt <= err_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// Directed, table-driven bench for abs_diff_approx_pipe; monitor checks
// are included when ABS_DIFF_ERR_MON_EN is defined.
module tb_abs_diff_approx_pipe;

`ifdef ABS_DIFF_ERR_MON_EN
   localparam int TRUNC = 3;
   localparam int ET    = 3;
   localparam int CNT_W = 3;
`else
   localparam int TRUNC = 1;
   localparam int ET    = 3;
   localparam int CNT_W = 16;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       in_exact;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_diff;
   logic       out_sign;
`ifdef ABS_DIFF_ERR_MON_EN
   logic [CNT_W-1:0] err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   abs_diff_approx_pipe #(.W(4), .TRUNC(TRUNC), .ET(ET), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_exact  (in_exact),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_diff  (out_diff),
      .out_sign  (out_sign)
`ifdef ABS_DIFF_ERR_MON_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       ex;
      logic [3:0] mag;
      logic       sign;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [3:0] exp_diff(input logic [3:0] m, input logic ex);
      logic [3:0] mask;
      mask = 4'((1 << TRUNC) - 1);
      return ex ? m : (m & ~mask);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

`ifdef ABS_DIFF_ERR_MON_EN
   task automatic send_one(input logic [3:0] a, input logic [3:0] b, input logic ex,
                           input logic [31:0] exp_cnt, input string name);
      in_valid = 1'b1; in_a = a; in_b = b; in_exact = ex;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk(name, 32'(err_cnt), exp_cnt);
   endtask
`endif

   logic [3:0] pa[3];
   logic [3:0] pb[3];
   int acc;

   initial begin
      // a, b, exact, exact magnitude, sign
      tbl[0] = '{4'd9,  4'd2,  1'b0, 4'd7,  1'b0};
      tbl[1] = '{4'd9,  4'd2,  1'b1, 4'd7,  1'b0};
      tbl[2] = '{4'd3,  4'd12, 1'b1, 4'd9,  1'b1};
      tbl[3] = '{4'd15, 4'd0,  1'b1, 4'd15, 1'b0};
      tbl[4] = '{4'd7,  4'd7,  1'b1, 4'd0,  1'b0};
      tbl[5] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0};
      tbl[6] = '{4'd0,  4'd15, 1'b0, 4'd15, 1'b1};
      tbl[7] = '{4'd1,  4'd0,  1'b0, 4'd1,  1'b0};
      pa[0] = 4'd5;  pb[0] = 4'd1;
      pa[1] = 4'd2;  pb[1] = 4'd9;
      pa[2] = 4'd11; pb[2] = 4'd4;

      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_diff", 32'(out_diff), 0);
      chk("rst_out_sign", 32'(out_sign), 0);
`ifdef ABS_DIFF_ERR_MON_EN
      chk("rst_err_cnt", 32'(err_cnt), 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // back-to-back stream: results two negedges after drive, no bubbles
      for (int i = 0; i < 10; i++) begin
         if (i >= 2) begin
            chk($sformatf("stream%0d_valid", i-2), 32'(out_valid), 1);
            chk($sformatf("stream%0d_diff", i-2), 32'(out_diff),
                32'(exp_diff(tbl[i-2].mag, tbl[i-2].ex)));
            chk($sformatf("stream%0d_sign", i-2), 32'(out_sign), 32'(tbl[i-2].sign));
         end
         if (i < 8) begin
            chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 1);
            in_valid = 1'b1; in_a = tbl[i].a; in_b = tbl[i].b; in_exact = tbl[i].ex;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("stream_drained", 32'(out_valid), 0);

      // backpressure: two accepted, then stall with stable outputs
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), (c < 2) ? 32'd1 : 32'd0);
         if (c >= 2) begin
            chk($sformatf("bp%0d_valid", c), 32'(out_valid), 1);
            chk($sformatf("bp%0d_diff", c), 32'(out_diff), 4);
            chk($sformatf("bp%0d_sign", c), 32'(out_sign), 0);
         end
         in_valid = 1'b1; in_a = pa[acc]; in_b = pb[acc]; in_exact = 1'b1;
         if (in_ready) acc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_hold_diff", 32'(out_diff), 4);
      @(negedge clk);
      chk("bp_second_valid", 32'(out_valid), 1);
      chk("bp_second_diff", 32'(out_diff), 7);
      chk("bp_second_sign", 32'(out_sign), 1);
      @(negedge clk);
      chk("bp_empty", 32'(out_valid), 0);
      chk("bp_new_in_ready", 32'(in_ready), 1);
      in_valid = 1'b1; in_a = pa[2]; in_b = pb[2]; in_exact = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_new_valid", 32'(out_valid), 1);
      chk("bp_new_diff", 32'(out_diff), 7);
      chk("bp_new_sign", 32'(out_sign), 0);
      @(negedge clk);

      // reset with two items in flight
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = pa[0]; in_b = pb[0]; in_exact = 1'b0;
      @(negedge clk);
      in_a = pa[1]; in_b = pb[1];
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 0);
      chk("midrst_diff", 32'(out_diff), 0);
`ifdef ABS_DIFF_ERR_MON_EN
      chk("midrst_err_cnt", 32'(err_cnt), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("no_stale%0d", k), 32'(out_valid), 0);
      end

`ifdef ABS_DIFF_ERR_MON_EN
      send_one(4'd15, 4'd0, 1'b0, 1, "mon_err7");
      send_one(4'd12, 4'd0, 1'b0, 2, "mon_err4");
      send_one(4'd8,  4'd0, 1'b0, 2, "mon_err0");
      send_one(4'd15, 4'd0, 1'b1, 2, "mon_exact");
      for (int k = 0; k < 6; k++)
         send_one(4'd15, 4'd0, 1'b0, (k + 3 > 7) ? 32'd7 : 32'(k + 3),
                  $sformatf("mon_sat%0d", k));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
